// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the shared-register
// round-robin write controller.
package dff_ctrl_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester handshake and shared-register bus
// between the controller and its environment.
interface dff_bank_arbiter_if
  import dff_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_d;
  logic [WIDTH-1:0]         reg_q;

  modport master (
    output req_valid,
    output req_data,
    output reg_q,
    input  req_ready,
    input  reg_en,
    input  reg_d
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  reg_q,
    output req_ready,
    output reg_en,
    output reg_d
  );

endinterface

// File: rtl/dff_bank_arbiter_rr.sv
// Combinational round-robin pick: first request
// at or above ptr, wrapping modulo N.
module rr_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // N is a power of two, so IW-bit addition wraps
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin writer for one shared DFF register
// with readback compare and saturating error count.
module dff_bank_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  dff_bank_arbiter_if.slave  bus,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               mismatch,
  output logic [CNT_W-1:0]   err_cnt
);

  state_t               state;
  state_t               state_n;
  logic [IW-1:0]        ptr;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     sel_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        win;
  logic                 any;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req(bus.req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );

  // one-hot AND-OR select of the winner's slice
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = sel_data
          | bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n       = state;
    bus.reg_en    = 1'b0;
    bus.req_ready = '0;
    mismatch      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) state_n = WRITE;
      end
      WRITE: begin
        bus.reg_en = 1'b1;
        state_n    = CHECK;
      end
      CHECK: begin
        bus.req_ready[grant_id] = 1'b1;
        mismatch = (bus.reg_q != data_q);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.reg_d = data_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      grant_id <= '0;
      data_q   <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == IDLE && any) begin
        grant_id <= win;
        data_q   <= sel_data;
        ptr      <= win + 1'b1;
      end
      if (mismatch && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: directed scenarios plus a
// random run against a transaction-level model.
module tb_dff_bank_arbiter;
  import dff_ctrl_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dff_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();

  logic         busy;
  logic [1:0]   grant_id;
  logic         mismatch;
  logic [C-1:0] err_cnt;

  dff_bank_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .CNT_W(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .mismatch(mismatch),
    .err_cnt(err_cnt)
  );

  // the shared register, optionally stuck at zero
  logic         force_zero;
  logic [W-1:0] q_mem = '0;
  always @(posedge clk)
    if (bus.reg_en) q_mem <= force_zero ? '0 : bus.reg_d;
  assign bus.reg_q = q_mem;

  int total = 0;
  int bad   = 0;

  // transaction-level model: phase 0 idle, 1 write, 2 check
  int           m_ph, m_ptr, m_gid, m_err;
  logic [W-1:0] m_data, m_q;

  function automatic logic [W-1:0] slice(int i);
    return bus.req_data[i*W +: W];
  endfunction

  function automatic logic [N-1:0] exp_ready();
    return (m_ph == 2) ? N'(1 << m_gid) : '0;
  endfunction

  function automatic logic exp_mis();
    return (m_ph == 2) && (m_q != m_data);
  endfunction

  task automatic tick();
    int w;
    if (!rst) begin
      m_ph = 0; m_ptr = 0; m_gid = 0;
      m_data = '0; m_err = 0;
    end else if (m_ph == 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req_valid[(m_ptr+k)%N])
          w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_gid = w; m_data = slice(w);
        m_ptr = (w + 1) % N; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      m_q  = force_zero ? '0 : m_data;
      m_ph = 2;
    end else begin
      if (m_q != m_data && m_err < (1 << C) - 1) m_err++;
      m_ph = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lo;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.req_valid = N'($urandom);
      bus.req_data  = $urandom;
      force_zero    = 1'b0;
      tick();
    end
    total++;
    if ({busy, grant_id, bus.reg_en, bus.reg_d,
         bus.req_ready, mismatch, err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%0h want=0",
        {busy, grant_id, bus.reg_en, bus.reg_d,
         bus.req_ready, mismatch, err_cnt});
    end
    rst = 1'b1;
    bus.req_valid = N'($urandom_range(1, 15));
    lo = 0;
    while (!bus.req_valid[lo]) lo++;
    tick();
    total++;
    if (grant_id !== 2'(lo) || bus.reg_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant got=%0d want=%0d",
        grant_id, lo);
    end
    bus.req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    bus.req_data  = $urandom;
    bus.req_data[2*W +: W] = 8'hA5;
    bus.req_valid = 4'b0100;
    tick();
    total++;
    if (grant_id !== 2'd2 || bus.reg_en !== 1'b1 ||
        bus.reg_d !== 8'hA5 || bus.req_ready !== 4'b0) begin
      bad++;
      $display("FAIL single_write gid=%0d en=%0b d=%0h rdy=%0b want 2 1 a5 0",
        grant_id, bus.reg_en, bus.reg_d, bus.req_ready);
    end
    tick();
    total++;
    if (bus.req_ready !== 4'b0100 || bus.reg_en !== 1'b0 ||
        mismatch !== 1'b0) begin
      bad++;
      $display("FAIL single_ack rdy=%0b en=%0b mis=%0b want 0100 0 0",
        bus.req_ready, bus.reg_en, mismatch);
    end
    bus.req_valid = '0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle busy=%0b want=0", busy);
    end
  endtask

  task automatic test_all_hold();
    int g;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bus.req_data = $urandom;
      g = k % N;
      tick();
      total++;
      if (grant_id !== 2'(g) || bus.reg_d !== slice(g) ||
          bus.reg_en !== 1'b1) begin
        bad++;
        $display("FAIL hold_grant k=%0d gid=%0d d=%0h want %0d %0h",
          k, grant_id, bus.reg_d, g, slice(g));
      end
      tick();
      total++;
      if (bus.req_ready !== N'(1 << g)) begin
        bad++;
        $display("FAIL hold_ack k=%0d got=%0b want=%0b",
          k, bus.req_ready, N'(1 << g));
      end
      tick();
      total++;
      if (bus.req_ready !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL hold_gap k=%0d rdy=%0b busy=%0b want 0 0",
          k, bus.req_ready, busy);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_mismatch();
    int want;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    force_zero    = 1'b1;
    bus.req_data  = '0;
    bus.req_data[W-1:0] = 8'hFF;
    bus.req_valid = 4'b0001;
    for (int t = 0; t < 301; t++) begin
      tick();
      tick();
      total++;
      if (mismatch !== 1'b1) begin
        bad++;
        $display("FAIL mis_pulse t=%0d got=%0b want=1", t, mismatch);
      end
      tick();
      want = (t + 1 > 255) ? 255 : t + 1;
      total++;
      if (err_cnt !== C'(want)) begin
        bad++;
        $display("FAIL mis_cnt t=%0d got=%0d want=%0d",
          t, err_cnt, want);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_write();
    bus.req_data  = $urandom;
    bus.req_valid = 4'b0100;
    tick();
    total++;
    if (bus.reg_en !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL rw_write en=%0b gid=%0d want 1 2",
        bus.reg_en, grant_id);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.req_ready !== '0 || busy !== 1'b0 ||
        err_cnt !== '0 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL rw_abort rdy=%0b busy=%0b cnt=%0d mis=%0b want 0",
        bus.req_ready, busy, err_cnt, mismatch);
    end
    rst = 1'b1;
    force_zero    = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    total++;
    if (grant_id !== 2'd0) begin
      bad++;
      $display("FAIL rw_ptr got=%0d want=0", grant_id);
    end
    tick();
    total++;
    if (bus.req_ready !== 4'b0001 || err_cnt !== '0) begin
      bad++;
      $display("FAIL rw_ack rdy=%0b cnt=%0d want 0001 0",
        bus.req_ready, err_cnt);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_drop();
    bus.req_data  = $urandom;
    bus.req_data[3*W +: W] = 8'h3C;
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    bus.req_data  = $urandom;
    total++;
    if (bus.reg_en !== 1'b1 || bus.reg_d !== 8'h3C) begin
      bad++;
      $display("FAIL drop_write en=%0b d=%0h want 1 3c",
        bus.reg_en, bus.reg_d);
    end
    tick();
    total++;
    if (bus.req_ready !== 4'b1000 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL drop_ack rdy=%0b mis=%0b want 1000 0",
        bus.req_ready, mismatch);
    end
    tick();
  endtask

  task automatic test_random();
    logic [30:0] got, want;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 39) != 0);
      bus.req_valid = N'($urandom);
      bus.req_data  = $urandom;
      force_zero    = ($urandom_range(0, 3) == 0);
      tick();
      got  = {busy, grant_id, bus.reg_en, bus.reg_d,
              bus.req_ready, mismatch, err_cnt};
      want = {m_ph != 0, 2'(m_gid), m_ph == 1, m_data,
              exp_ready(), exp_mis(), C'(m_err)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rand c=%0d got=%0h want=%0h", c, got, want);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    force_zero    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    m_ph = 0; m_ptr = 0; m_gid = 0; m_err = 0;
    m_data = '0; m_q = '0;
    test_reset();
    test_single();
    test_all_hold();
    test_mismatch();
    test_reset_write();
    test_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write controller that shares a single WIDTH-bit D-flip-flop register between NUM_REQ requesters. Each accepted request is written into the shared register, read back from its q output one cycle later, and compared against the written value. A per-transaction ack goes back to the requester, and mismatches are counted. The block sits in front of the shared register and is the only agent driving its d and enable inputs.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2 and a power of two.
- WIDTH, 8: data width of the shared register.
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  input  NUM_REQ  per-requester request.
- req_data  input  NUM_REQ*WIDTH  per-requester write data; slice i is bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot, one-cycle ack to the granted requester.
- reg_en  output  1  write enable to the shared register.
- reg_d  output  WIDTH  data to the shared register.
- reg_q  input  WIDTH  registered output of the shared register.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
- mismatch  output  1  one-cycle pulse when readback differs from written data.
- err_cnt  output  CNT_W  saturating count of mismatches.

## Operation
- State machine with three states: IDLE, WRITE, CHECK.
- IDLE:
  - If any req_valid is high, pick a winner by round-robin, searching upward from ptr with wrap.
  - Latch the winner's index into grant_id and its data slice into data_q.
  - Set ptr to (winner+1) mod NUM_REQ and go to WRITE.
  - Otherwise stay in IDLE.
- WRITE: reg_en=1 and reg_d=data_q for exactly one cycle, then go to CHECK.
- CHECK:
  - Drive req_ready[grant_id]=1.
  - Compare reg_q to data_q. On inequality, pulse mismatch and increment err_cnt, saturating at all-ones.
  - Go to IDLE.
- reg_d holds data_q in every state; it is only meaningful while reg_en=1.
- Requester protocol:
  - A requester holds req_valid until it sees req_ready.
  - Data is sampled only at grant. Changing or dropping req_data or req_valid after grant does not affect the transaction in flight, which still completes and acks.
- A requester still asserting valid after its ack is treated as a new request and competes normally in the next IDLE cycle.

## Timing
- Reset (rst=0 at an edge):
  - Outputs after that edge: state=IDLE, ptr=0, grant_id=0, data_q=0, reg_en=0, reg_d=0, req_ready=0, busy=0, mismatch=0, err_cnt=0.
  - A reset in WRITE or CHECK aborts the transaction: no ack, no counter update.
- Transaction cycle sequence: grant edge (IDLE→WRITE) → WRITE cycle (reg_en high) → CHECK cycle (ack and compare) → IDLE.
  - Minimum of 3 cycles per transaction, from the edge where valid is sampled to IDLE re-entry.
  - Back-to-back throughput is 1 transaction per 3 cycles.
- reg_q is compared in the CHECK cycle, one cycle after the register captures at the end of WRITE.
- All requesters valid continuously: grant order is 0,1,2,3,0,…
- A single requester valid continuously: it is granted every 3 cycles.
- err_cnt at saturation stays at all-ones, while mismatch still pulses.

## Structure
- Package dff_ctrl_pkg holds:
  - the state enum typedef (IDLE, WRITE, CHECK);
  - the default parameter constants.
- Sub-module rr_arbiter is combinational. It takes request vector + ptr and returns a one-hot grant plus the encoded index. The FSM, latches and counter stay in the top module.

## Test plan
- Hold rst=0 for 2 cycles with random inputs → all outputs 0, busy=0. Release → first grant goes to the lowest-indexed valid requester.
- Only requester 2 valid with data 0xA5 → grant_id=2, reg_en high for 1 cycle with reg_d=0xA5, req_ready=4'b0100 two cycles after grant, mismatch=0.
- All 4 requesters valid and held → acks on 0,1,2,3,0 spaced 3 cycles apart.
- Model forces reg_q=0x00 while 0xFF is written → mismatch pulse, err_cnt=1. Repeat 300 times → err_cnt stays at 255.
- Assert rst=0 during the WRITE cycle → no req_ready, err_cnt unchanged. Next grant starts from ptr=0.
- Requester drops valid and changes data right after grant → original latched data is written and the ack is still issued.
